eth10_tx_sched: RTL and testbench

- Scheduler and arbiter in front of the 10BASE-T transmit datapath (ETH10base_t_tx).
- Shares the single transmitter between NREQ frame sources.
- Enforces the inter-frame gap (IFG) after every frame.
- Generates normal link pulses (NLP) while the line is idle, and drives the stretched Led_Tx activity indicator.

---
 rtl/eth10_tx_sched.sv | 165 ++++++++++++++++
 tb/tb_eth10_tx_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth10_tx_sched.sv
// Transmit scheduler for a 10BASE-T datapath: arbitrates frame sources, enforces IFG,
// emits idle link pulses and stretches Led_Tx. Define ETH10_TX_SCHED_RR_EN for round-robin arbitration.
module eth10_tx_sched #(
    parameter int NREQ      = 2,
    parameter int IFG_CYC   = 192,
    parameter int NLP_CYC   = 320000,
    parameter int NLP_W_CYC = 2,
    parameter int LED_CYC   = 2000000,
    parameter int START_TO  = 8,
    localparam int SELW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] tx_sel,
    output logic            tx_start,
    input  logic            tx_busy,
    output logic            nlp,
    output logic            tx_err,
    output logic            Led_Tx
);

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, BUSY, IFG, NLP} state_t;

    localparam int PH_MAX = (IFG_CYC > START_TO) ? ((IFG_CYC > NLP_W_CYC) ? IFG_CYC : NLP_W_CYC)
                                                 : ((START_TO > NLP_W_CYC) ? START_TO : NLP_W_CYC);
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int IDLE_W = $clog2(NLP_CYC + 1);
    localparam int LED_W  = (LED_CYC > 0) ? $clog2(LED_CYC + 1) : 1;

    localparam logic [PH_W-1:0]   IFG_LAST   = PH_W'(IFG_CYC - 1);
    localparam logic [PH_W-1:0]   TO_LAST    = PH_W'(START_TO - 1);
    localparam logic [PH_W-1:0]   NLPW_LAST  = PH_W'(NLP_W_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(NLP_CYC - 1);
    localparam logic [LED_W-1:0]  LED_RELOAD = LED_W'(LED_CYC);

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [SELW-1:0]   sel_q, sel_d;

    logic              any_req;
    logic [NREQ-1:0]   req_rot;
    logic [SELW-1:0]   rot_pos;
    logic [SELW-1:0]   arb_idx;
    logic [NREQ-1:0]   arb_gnt;

`ifdef ETH10_TX_SCHED_RR_EN
    localparam logic [SELW:0]   NREQ_X   = (SELW + 1)'(NREQ);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NREQ - 1);
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [2*NREQ-1:0] req_dbl;
    logic [SELW:0]     idx_sum;
`endif

    assign any_req = |req;

    // Rotate requests so the search origin sits at bit 0, then take the lowest set bit.
    always_comb begin
`ifdef ETH10_TX_SCHED_RR_EN
        req_dbl = {req, req} >> ptr_q;
        req_rot = req_dbl[NREQ-1:0];
`else
        req_rot = req;
`endif
        rot_pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) rot_pos = SELW'(k);
        end
`ifdef ETH10_TX_SCHED_RR_EN
        idx_sum = {1'b0, ptr_q} + {1'b0, rot_pos};
        if (idx_sum >= NREQ_X) idx_sum = idx_sum - NREQ_X;
        arb_idx = idx_sum[SELW-1:0];
        ptr_d   = ptr_q;
        if (state_q == IDLE && any_req) ptr_d = (arb_idx == SEL_LAST) ? '0 : arb_idx + 1'b1;
`else
        arb_idx = rot_pos;
`endif
        arb_gnt = NREQ'(1) << arb_idx;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ph_cnt_q   <= '0;
            idle_cnt_q <= '0;
            led_cnt_q  <= '0;
            gnt_q      <= '0;
            sel_q      <= '0;
`ifdef ETH10_TX_SCHED_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            led_cnt_q  <= led_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
`ifdef ETH10_TX_SCHED_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // A pending request beats a due link pulse; a running pulse is never cut short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req)                       state_d = START;
                else if (idle_cnt_q == IDLE_LAST)  state_d = NLP;
            end
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)                       state_d = BUSY;
                else if (ph_cnt_q == TO_LAST)      state_d = IFG;
            end
            BUSY:      if (!tx_busy)               state_d = IFG;
            IFG:       if (ph_cnt_q == IFG_LAST)   state_d = IDLE;
            NLP:       if (ph_cnt_q == NLPW_LAST)  state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_d != state_q)                       ph_cnt_d = '0;
        else if (state_q inside {WAIT_BUSY, IFG, NLP}) ph_cnt_d = ph_cnt_q + 1'b1;
        else                                          ph_cnt_d = '0;

        // idle_cnt measures time since the last frame end or link pulse.
        idle_cnt_d = idle_cnt_q;
        if (state_q == IDLE && idle_cnt_q != IDLE_LAST) idle_cnt_d = idle_cnt_q + 1'b1;
        if ((state_q == IFG || state_q == NLP) && state_d == IDLE) idle_cnt_d = '0;

        if (state_d == START)        led_cnt_d = LED_RELOAD;
        else if (led_cnt_q != '0)    led_cnt_d = led_cnt_q - 1'b1;
        else                         led_cnt_d = led_cnt_q;

        gnt_d = gnt_q;
        sel_d = sel_q;
        if (state_q == IDLE && any_req) begin
            gnt_d = arb_gnt;
            sel_d = arb_idx;
        end
        if (state_d == IFG && state_q != IFG) begin
            gnt_d = '0;
            sel_d = '0;
        end
    end

    always_comb begin
        tx_start = (state_q == START);
        nlp      = (state_q == NLP);
        tx_err   = (state_q == WAIT_BUSY) && !tx_busy && (ph_cnt_q == TO_LAST);
        Led_Tx   = (state_q == START) || (led_cnt_q != '0);
    end

    assign gnt    = gnt_q;
    assign tx_sel = sel_q;

endmodule

// File: tb/tb_eth10_tx_sched.sv
// Bench for eth10_tx_sched: scenario tasks plus randomized frames against an arithmetic timing/arbitration model.
module tb_eth10_tx_sched;
    localparam int NREQ = 2, IFG_CYC = 8, NLP_CYC = 100, NLP_W_CYC = 2, LED_CYC = 20, START_TO = 8;
    localparam int SELW = 1;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            tx_busy = 1'b0;
    logic [NREQ-1:0] gnt;
    logic [SELW-1:0] tx_sel;
    logic            tx_start, nlp, tx_err, Led_Tx;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    bit dp_en = 1'b1;
    int busy_len = 30;
    int dp_len;
    int model_last = NREQ - 1;
    int last_s;

    eth10_tx_sched #(.NREQ(NREQ), .IFG_CYC(IFG_CYC), .NLP_CYC(NLP_CYC), .NLP_W_CYC(NLP_W_CYC),
                     .LED_CYC(LED_CYC), .START_TO(START_TO)) dut (
        .clk(clk), .resetn(resetn), .req(req), .gnt(gnt), .tx_sel(tx_sel), .tx_start(tx_start),
        .tx_busy(tx_busy), .nlp(nlp), .tx_err(tx_err), .Led_Tx(Led_Tx));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: busy rises 2 cycles after tx_start and stays up busy_len cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start && dp_en) begin
                dp_len = busy_len;
                @(negedge clk);
                @(negedge clk);
                tx_busy = 1'b1;
                repeat (dp_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end

    // Reference arbitration rule: first requester after the last grant (or lowest index).
    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        logic [NREQ-1:0] sh;
`ifdef ETH10_TX_SCHED_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            sh = r >> i;
            if (sh[0]) return i;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            sh = r >> i;
            if (sh[0]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_last = NREQ - 1;
    endtask

    task automatic wait_start(input int budget, output int at, output bit ok);
        at = -1;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_start) begin
                at = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int c0, hi, st, r1, r2;
        int rises[$];
        logic prev;
        resetn = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({gnt, tx_sel, tx_start, nlp, tx_err, Led_Tx} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {gnt, tx_sel, tx_start, nlp, tx_err, Led_Tx});
        end
        resetn = 1'b1;
        model_last = NREQ - 1;
        c0 = cyc; hi = 0; st = 0; prev = 1'b0;
        for (int k = 0; k < 210; k++) begin
            @(negedge clk);
            if (nlp && !prev) rises.push_back(cyc - c0);
            if (nlp) hi++;
            if (tx_start) st++;
            prev = nlp;
        end
        r1 = (rises.size() > 0) ? rises[0] : -1;
        r2 = (rises.size() > 1) ? rises[1] : -1;
        n_tests++;
        if (r1 != NLP_CYC) begin n_fail++; $display("FAIL first_nlp: got %0d required %0d", r1, NLP_CYC); end
        n_tests++;
        if (r2 - r1 != NLP_CYC + NLP_W_CYC) begin
            n_fail++; $display("FAIL nlp_period: got %0d required %0d", r2 - r1, NLP_CYC + NLP_W_CYC);
        end
        n_tests++;
        if (hi != 2 * NLP_W_CYC) begin n_fail++; $display("FAIL nlp_width: got %0d required %0d", hi, 2 * NLP_W_CYC); end
        n_tests++;
        if (st != 0) begin n_fail++; $display("FAIL idle_no_start: got %0d required 0", st); end
    endtask

    task automatic test_single();
        int c0, ts, e, led_off, gnt_off, st;
        bit ok;
        logic [NREQ-1:0] eg;
        logic [SELW-1:0] es;
        busy_len = 30;
        c0 = cyc;
        req = 2'b01;
        e = pick(req, model_last);
        eg = NREQ'(1) << e; es = SELW'(e);
        wait_start(50, ts, ok);
        n_tests++;
        if (!ok || ts != c0 + 1) begin n_fail++; $display("FAIL single_start: got %0d required %0d", ts, c0 + 1); end
        n_tests++;
        if (gnt !== eg || tx_sel !== es) begin
            n_fail++; $display("FAIL single_gnt: got %b/%0d required %b/%0d", gnt, tx_sel, eg, es);
        end
        n_tests++;
        if (Led_Tx !== 1'b1) begin n_fail++; $display("FAIL led_on: got %b required 1", Led_Tx); end
        req = '0;
        model_last = e;
        led_off = -1; gnt_off = -1; st = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (!Led_Tx && led_off < 0) led_off = cyc - ts;
            if (gnt == '0 && gnt_off < 0) gnt_off = cyc - ts;
            if (tx_start) st++;
        end
        n_tests++;
        if (led_off != LED_CYC) begin n_fail++; $display("FAIL led_stretch: got %0d required %0d", led_off, LED_CYC); end
        n_tests++;
        if (gnt_off != 2 + busy_len + 1) begin
            n_fail++; $display("FAIL gnt_release: got %0d required %0d", gnt_off, 2 + busy_len + 1);
        end
        n_tests++;
        if (st != 0) begin n_fail++; $display("FAIL single_pulse: extra starts %0d required 0", st); end
    endtask

    task automatic test_rr();
        int exp_at, at, e;
        bit ok;
        logic [NREQ-1:0] eg;
        logic [SELW-1:0] es;
        apply_reset();
        busy_len = 30;
        req = 2'b11;
        exp_at = cyc + 1;
        at = -1;
        for (int f = 0; f < 3; f++) begin
            e = pick(req, model_last);
            eg = NREQ'(1) << e; es = SELW'(e);
            wait_start(100, at, ok);
            n_tests++;
            if (!ok || at != exp_at) begin n_fail++; $display("FAIL rr_timing%0d: got %0d required %0d", f, at, exp_at); end
            n_tests++;
            if (gnt !== eg || tx_sel !== es) begin
                n_fail++; $display("FAIL rr_gnt%0d: got %b/%0d required %b/%0d", f, gnt, tx_sel, eg, es);
            end
            model_last = e;
            exp_at = at + 2 + busy_len + IFG_CYC + 2;
        end
        req = '0;
        last_s = at;
    endtask

    task automatic test_nlp_tie();
        int target, bad_nlp, bad_st, at, first_nlp, e;
        bit ok;
        logic prev;
        target = last_s + 2 + busy_len + 1 + IFG_CYC + NLP_CYC - 1;
        bad_nlp = 0; bad_st = 0;
        while (cyc < target) begin
            @(negedge clk);
            if (nlp) bad_nlp++;
            if (tx_start) bad_st++;
        end
        req = 2'b01;
        e = pick(req, model_last);
        wait_start(5, at, ok);
        if (nlp) bad_nlp++;
        n_tests++;
        if (!ok || at != target + 1) begin n_fail++; $display("FAIL tie_start: got %0d required %0d", at, target + 1); end
        n_tests++;
        if (bad_nlp != 0 || bad_st != 0) begin
            n_fail++; $display("FAIL tie_no_nlp: nlp %0d starts %0d required 0 0", bad_nlp, bad_st);
        end
        req = '0;
        model_last = e;
        first_nlp = -1; prev = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            if (nlp && !prev && first_nlp < 0) first_nlp = cyc - at;
            prev = nlp;
        end
        n_tests++;
        if (first_nlp != 2 + busy_len + 1 + IFG_CYC + NLP_CYC) begin
            n_fail++;
            $display("FAIL nlp_after_frame: got %0d required %0d", first_nlp, 2 + busy_len + 1 + IFG_CYC + NLP_CYC);
        end
    endtask

    task automatic test_timeout();
        int t, e, err_at, errc, s2;
        bit ok;
        logic [NREQ-1:0] eg, gnt_ifg, gnt2;
        dp_en = 1'b0;
        busy_len = 30;
        req = 2'b10;
        e = pick(req, model_last);
        eg = NREQ'(1) << e;
        wait_start(10, t, ok);
        n_tests++;
        if (!ok || gnt !== eg) begin n_fail++; $display("FAIL to_gnt: got %b required %b", gnt, eg); end
        model_last = e;
        err_at = -1; errc = 0; s2 = -1; gnt_ifg = 'x; gnt2 = 'x;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_err) begin
                errc++;
                if (err_at < 0) err_at = cyc - t;
                dp_en = 1'b1;
            end
            if (cyc == t + START_TO + 1) gnt_ifg = gnt;
            if (tx_start) begin
                s2 = cyc - t;
                gnt2 = gnt;
                break;
            end
        end
        e = pick(req, model_last);
        eg = NREQ'(1) << e;
        n_tests++;
        if (err_at != START_TO) begin n_fail++; $display("FAIL err_time: got %0d required %0d", err_at, START_TO); end
        n_tests++;
        if (errc != 1) begin n_fail++; $display("FAIL err_count: got %0d required 1", errc); end
        n_tests++;
        if (gnt_ifg !== '0) begin n_fail++; $display("FAIL err_gnt_clear: got %b required 0", gnt_ifg); end
        n_tests++;
        if (s2 != START_TO + IFG_CYC + 2 || gnt2 !== eg) begin
            n_fail++; $display("FAIL regrant: got %0d/%b required %0d/%b", s2, gnt2, START_TO + IFG_CYC + 2, eg);
        end
        model_last = e;
        req = '0;
        last_s = t + s2;
    endtask

    task automatic test_reset_mid();
        int c0, first_nlp, st;
        logic prev;
        logic [NREQ-1:0] eg;
        eg = NREQ'(1) << model_last;
        while (cyc < last_s + 10) @(negedge clk);
        n_tests++;
        if (Led_Tx !== 1'b1 || gnt !== eg) begin
            n_fail++; $display("FAIL busy_state: got led %b gnt %b required 1 %b", Led_Tx, gnt, eg);
        end
        resetn = 1'b0;
        @(negedge clk);
        n_tests++;
        if (gnt !== '0 || Led_Tx !== 1'b0 || nlp !== 1'b0 || tx_start !== 1'b0 || tx_sel !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got gnt %b led %b nlp %b start %b sel %0d required all 0",
                     gnt, Led_Tx, nlp, tx_start, tx_sel);
        end
        resetn = 1'b1;
        model_last = NREQ - 1;
        c0 = cyc; first_nlp = -1; st = 0; prev = 1'b0;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (nlp && !prev && first_nlp < 0) first_nlp = cyc - c0;
            if (tx_start) st++;
            prev = nlp;
        end
        n_tests++;
        if (first_nlp != NLP_CYC || st != 0) begin
            n_fail++; $display("FAIL post_reset_nlp: got %0d/%0d required %0d/0", first_nlp, st, NLP_CYC);
        end
    endtask

    task automatic test_random();
        int ready, d, c, e, at, exp_at;
        bit ok;
        logic [NREQ-1:0] rv, eg;
        logic [SELW-1:0] es;
        ready = 0;
        for (int it = 0; it < 12; it++) begin
            busy_len = int'($urandom_range(1, 30));
            d = int'($urandom_range(0, 40));
            repeat (d) @(negedge clk);
            c = cyc;
            rv = NREQ'($urandom_range(1, 3));
            req = rv;
            e = pick(rv, model_last);
            eg = NREQ'(1) << e; es = SELW'(e);
            exp_at = (ready > c + 1) ? ready : c + 1;
            wait_start(150, at, ok);
            n_tests++;
            if (!ok || at != exp_at) begin n_fail++; $display("FAIL rand_timing%0d: got %0d required %0d", it, at, exp_at); end
            n_tests++;
            if (gnt !== eg || tx_sel !== es) begin
                n_fail++; $display("FAIL rand_gnt%0d: req %b got %b/%0d required %b/%0d", it, rv, gnt, tx_sel, eg, es);
            end
            req = '0;
            model_last = e;
            ready = at + 2 + busy_len + IFG_CYC + 2;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_nlp_tie();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
